// File: rtl/dds_freq_update_ctrl_if.sv
// Update handshake between the frequency-update controller and the DDS core.
// The master offers Pinc/Wave_sel with Upd_valid; the core accepts with Upd_ack.
interface dds_freq_update_ctrl_if #(
  parameter int PINC_W = 32
);
  logic [PINC_W-1:0] Pinc;
  logic [2:0]        Wave_sel;
  logic              Upd_valid;
  logic              Upd_ack;

  modport master (
    output Pinc,
    output Wave_sel,
    output Upd_valid,
    input  Upd_ack
  );

  modport slave (
    input  Pinc,
    input  Wave_sel,
    input  Upd_valid,
    output Upd_ack
  );
endinterface

// File: rtl/dds_freq_update_ctrl.sv
// Sequences encoder/mode triggers through the tuning ROM into the DDS core,
// optionally aligned to a phase-accumulator wrap.
module dds_freq_update_ctrl #(
  parameter int PINC_W       = 32,
  parameter int ROM_LAT      = 2,
  parameter int ACK_TIMEOUT  = 1023,
  parameter int WRAP_TIMEOUT = 4095
) (
  input  logic                   Fg_clk,
  input  logic                   Reset,
  input  logic [10:0]            Address,
  input  logic                   FreqChng,
  input  logic [2:0]             Mode,
  input  logic                   Sync_en,
  input  logic                   Phase_wrap,
  output logic                   Rom_en,
  output logic [10:0]            Rom_addr,
  input  logic [PINC_W-1:0]      Rom_data,
  dds_freq_update_ctrl_if.master upd,
  output logic                   Busy,
  output logic                   Err
);
  localparam int LAT_W  = $clog2(ROM_LAT + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int WRAP_W = $clog2(WRAP_TIMEOUT + 1);

  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(ROM_LAT - 1);
  localparam logic [ACK_W-1:0]  ACK_LIM  = ACK_W'(ACK_TIMEOUT);
  localparam logic [WRAP_W-1:0] WRAP_LIM = WRAP_W'(WRAP_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, SYNC, UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        mode_q, mode_d;
  logic              boot_q, boot_d;
  logic              pending_q, pending_d;
  logic [10:0]       req_addr_q, req_addr_d;
  logic [2:0]        req_mode_q, req_mode_d;
  logic [10:0]       use_addr_q, use_addr_d;
  logic [2:0]        use_mode_q, use_mode_d;
  logic [PINC_W-1:0] pinc_q, pinc_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ACK_W-1:0]  ack_q, ack_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  logic              trig;
  logic [ACK_W-1:0]  ack_inc;
  logic [WRAP_W-1:0] wrap_inc;

  assign trig = FreqChng | (Mode != mode_q) | boot_q;

  // Timeout counters saturate rather than wrap
  assign ack_inc  = (ack_q == ACK_LIM) ? ack_q
                                       : ack_q + ACK_W'(1);
  assign wrap_inc = (wrap_q == WRAP_LIM) ? wrap_q
                                         : wrap_q + WRAP_W'(1);

  always_ff @(posedge Fg_clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      boot_q     <= 1'b1;
      pending_q  <= 1'b0;
      req_addr_q <= '0;
      req_mode_q <= '0;
      use_addr_q <= '0;
      use_mode_q <= '0;
      pinc_q     <= '0;
      lat_q      <= '0;
      ack_q      <= '0;
      wrap_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      boot_q     <= boot_d;
      pending_q  <= pending_d;
      req_addr_q <= req_addr_d;
      req_mode_q <= req_mode_d;
      use_addr_q <= use_addr_d;
      use_mode_q <= use_mode_d;
      pinc_q     <= pinc_d;
      lat_q      <= lat_d;
      ack_q      <= ack_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    boot_d     = boot_q;
    pending_d  = pending_q;
    req_addr_d = req_addr_q;
    req_mode_d = req_mode_q;
    use_addr_d = use_addr_q;
    use_mode_d = use_mode_q;
    pinc_d     = pinc_q;
    lat_d      = lat_q;
    ack_d      = '0;
    wrap_d     = '0;

    if (trig) begin
      req_addr_d = Address;
      req_mode_d = Mode;
      mode_d     = Mode;
      boot_d     = 1'b0;
      if (state_q != IDLE) pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (trig || pending_q) begin
          state_d    = FETCH;
          pending_d  = 1'b0;
          // Snapshot taken here; later triggers only feed the next pass
          use_addr_d = trig ? Address : req_addr_q;
          use_mode_d = trig ? Mode : req_mode_q;
        end
      end
      FETCH: begin
        lat_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          pinc_d  = Rom_data;
          state_d = Sync_en ? SYNC : UPDATE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      SYNC: begin
        if (Phase_wrap) begin
          state_d = UPDATE;
        end else if (wrap_inc == WRAP_LIM) begin
          state_d = UPDATE;
        end else begin
          wrap_d = wrap_inc;
        end
      end
      UPDATE: begin
        if (upd.Upd_ack) begin
          state_d = IDLE;
        end else if (ack_inc == ACK_LIM) begin
          state_d = IDLE;
        end else begin
          ack_d = ack_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Rom_en        = (state_q == FETCH);
    Rom_addr      = Rom_en ? use_addr_q : '0;
    upd.Upd_valid = (state_q == UPDATE);
    upd.Pinc      = pinc_q;
    upd.Wave_sel  = use_mode_q;
    Busy          = (state_q != IDLE);
    Err           = 1'b0;
    if (state_q == SYNC && !Phase_wrap
        && wrap_inc == WRAP_LIM)
      Err = 1'b1;
    if (state_q == UPDATE && !upd.Upd_ack
        && ack_inc == ACK_LIM)
      Err = 1'b1;
  end
endmodule

// File: tb/tb_dds_freq_update_ctrl.sv
// Scoreboard bench for dds_freq_update_ctrl: expected ROM reads and
// handshakes are queued at stimulus time and popped by a monitor.
module tb_dds_freq_update_ctrl;
  localparam int PINC_W       = 32;
  localparam int ROM_LAT      = 2;
  localparam int ACK_TIMEOUT  = 1023;
  localparam int WRAP_TIMEOUT = 4095;

  typedef struct packed {
    logic [31:0] pinc;
    logic [2:0]  ws;
  } upd_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic [10:0] Address;
  logic        FreqChng;
  logic [2:0]  Mode;
  logic        Sync_en;
  logic        Phase_wrap;
  logic        Rom_en;
  logic [10:0] Rom_addr;
  logic [31:0] Rom_data;
  logic        Busy;
  logic        Err;

  dds_freq_update_ctrl_if #(.PINC_W(PINC_W)) upd ();

  dds_freq_update_ctrl #(
    .PINC_W(PINC_W),
    .ROM_LAT(ROM_LAT),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .WRAP_TIMEOUT(WRAP_TIMEOUT)
  ) dut (
    .Fg_clk(clk),
    .Reset(Reset),
    .Address(Address),
    .FreqChng(FreqChng),
    .Mode(Mode),
    .Sync_en(Sync_en),
    .Phase_wrap(Phase_wrap),
    .Rom_en(Rom_en),
    .Rom_addr(Rom_addr),
    .Rom_data(Rom_data),
    .upd(upd),
    .Busy(Busy),
    .Err(Err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [10:0] a);
    if (a == 11'd500) return 32'h00A0_0000;
    return 32'h0000_1000 + {17'h0, a, 4'h0};
  endfunction

  logic [10:0] rom_pipe [ROM_LAT];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_pipe[0] <= Rom_addr;
    for (int i = 1; i < ROM_LAT; i++)
      rom_pipe[i] <= rom_pipe[i-1];
  end

  assign Rom_data = rom_fn(rom_pipe[ROM_LAT-1]);

  logic [10:0] exp_rom [$];
  upd_t        exp_upd [$];
  logic [10:0] e_addr;
  upd_t        e_upd;
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (Err === 1'b1) err_cnt++;
    if (Rom_en === 1'b1) begin
      checks++;
      if (exp_rom.size() == 0) begin
        errors++;
        $display("FAIL rom_unexpected got addr=%0d want none",
                 Rom_addr);
      end else begin
        e_addr = exp_rom.pop_front();
        if (Rom_addr !== e_addr) begin
          errors++;
          $display("FAIL rom_addr got %0d want %0d",
                   Rom_addr, e_addr);
        end
      end
    end
    if (upd.Upd_valid === 1'b1 && upd.Upd_ack === 1'b1) begin
      hs_cnt++;
      checks++;
      if (exp_upd.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected got pinc=%h ws=%0d want none",
                 upd.Pinc, upd.Wave_sel);
      end else begin
        e_upd = exp_upd.pop_front();
        if (upd.Pinc !== e_upd.pinc || upd.Wave_sel !== e_upd.ws) begin
          errors++;
          $display("FAIL upd_data got pinc=%h ws=%0d want pinc=%h ws=%0d",
                   upd.Pinc, upd.Wave_sel, e_upd.pinc, e_upd.ws);
        end
      end
    end
  end

  task automatic nxt(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Address = '0;
    FreqChng = 1'b0;
    Mode = '0;
    Sync_en = 1'b0;
    Phase_wrap = 1'b0;
    upd.Upd_ack = 1'b0;
    nxt(3);
    @(negedge clk);
    checks++;
    if ({upd.Upd_valid, Rom_en, Busy, Err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000",
               {upd.Upd_valid, Rom_en, Busy, Err});
    end
    checks++;
    if (upd.Pinc !== 32'h0 || upd.Wave_sel !== 3'd0
        || Rom_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_data got pinc=%h ws=%0d addr=%0d want 0",
               upd.Pinc, upd.Wave_sel, Rom_addr);
    end
    nxt();
  endtask

  task automatic test_boot;
    logic        ren [7];
    logic        val [7];
    logic        bsy [7];
    logic [31:0] pv  [7];
    Address = 11'd0;
    Mode = 3'd0;
    Sync_en = 1'b0;
    upd.Upd_ack = 1'b1;
    exp_rom.push_back(11'd0);
    exp_upd.push_back({32'h0000_1000, 3'd0});
    Reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ren[c] = Rom_en;
      val[c] = upd.Upd_valid;
      bsy[c] = Busy;
      pv[c]  = upd.Pinc;
      nxt();
    end
    checks++;
    if ({ren[0], ren[1], ren[2]} !== 3'b010) begin
      errors++;
      $display("FAIL boot_rom_en got %b want 010",
               {ren[0], ren[1], ren[2]});
    end
    checks++;
    if ({val[3], val[4], val[5]} !== 3'b010) begin
      errors++;
      $display("FAIL boot_valid got %b want 010",
               {val[3], val[4], val[5]});
    end
    checks++;
    if (pv[4] !== 32'h0000_1000) begin
      errors++;
      $display("FAIL boot_pinc got %h want 00001000", pv[4]);
    end
    checks++;
    if ({bsy[1], bsy[5]} !== 2'b10) begin
      errors++;
      $display("FAIL boot_busy got %b want 10", {bsy[1], bsy[5]});
    end
  endtask

  task automatic test_sync;
    logic early = 1'b0;
    logic v_at, v_next;
    Sync_en = 1'b1;
    upd.Upd_ack = 1'b1;
    Address = 11'd500;
    exp_rom.push_back(11'd500);
    exp_upd.push_back({32'h00A0_0000, 3'd0});
    FreqChng = 1'b1;
    nxt();
    FreqChng = 1'b0;
    nxt();
    Phase_wrap = 1'b1;
    nxt();
    Phase_wrap = 1'b0;
    for (int k = 3; k < 20; k++) begin
      @(negedge clk);
      if (upd.Upd_valid !== 1'b0) early = 1'b1;
      nxt();
    end
    Phase_wrap = 1'b1;
    @(negedge clk);
    v_at = upd.Upd_valid;
    nxt();
    Phase_wrap = 1'b0;
    @(negedge clk);
    v_next = upd.Upd_valid;
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL sync_early_valid got 1 want 0");
    end
    checks++;
    if ({v_at, v_next} !== 2'b01) begin
      errors++;
      $display("FAIL sync_valid_after_wrap got %b want 01",
               {v_at, v_next});
    end
    nxt();
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL sync_done_busy got %b want 0", Busy);
    end
    Sync_en = 1'b0;
    nxt();
  endtask

  task automatic test_coalesce;
    int h0 = hs_cnt;
    upd.Upd_ack = 1'b0;
    exp_rom.push_back(11'd100);
    exp_upd.push_back({rom_fn(11'd100), 3'd0});
    exp_rom.push_back(11'd300);
    exp_upd.push_back({rom_fn(11'd300), 3'd0});
    Address = 11'd100;
    FreqChng = 1'b1;
    nxt();
    FreqChng = 1'b0;
    nxt();
    Address = 11'd200;
    FreqChng = 1'b1;
    nxt();
    FreqChng = 1'b0;
    nxt();
    Address = 11'd300;
    FreqChng = 1'b1;
    @(negedge clk);
    checks++;
    if (upd.Upd_valid !== 1'b1) begin
      errors++;
      $display("FAIL coal_first_valid got %b want 1", upd.Upd_valid);
    end
    nxt();
    FreqChng = 1'b0;
    upd.Upd_ack = 1'b1;
    nxt();
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL coal_idle_busy got %b want 0", Busy);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (Rom_en !== 1'b1) begin
      errors++;
      $display("FAIL coal_restart_rom_en got %b want 1", Rom_en);
    end
    nxt(6);
    checks++;
    if (hs_cnt - h0 !== 2) begin
      errors++;
      $display("FAIL coal_handshakes got %0d want 2", hs_cnt - h0);
    end
  endtask

  task automatic test_mode;
    int h0 = hs_cnt;
    upd.Upd_ack = 1'b1;
    exp_rom.push_back(11'd300);
    exp_upd.push_back({rom_fn(11'd300), 3'd4});
    Mode = 3'd4;
    nxt(8);
    checks++;
    if (hs_cnt - h0 !== 1) begin
      errors++;
      $display("FAIL mode_handshake got %0d want 1", hs_cnt - h0);
    end
    nxt(12);
    @(negedge clk);
    checks++;
    if (hs_cnt - h0 !== 1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mode_hold got hs=%0d busy=%b want hs=1 busy=0",
               hs_cnt - h0, Busy);
    end
    nxt();
  endtask

  task automatic test_ack_timeout;
    int   h0 = hs_cnt;
    int   e0 = err_cnt;
    int   t0;
    int   ecyc = 0;
    logic found = 1'b0;
    logic vlast = 1'b0;
    upd.Upd_ack = 1'b0;
    Address = 11'd7;
    exp_rom.push_back(11'd7);
    t0 = cyc;
    FreqChng = 1'b1;
    nxt();
    FreqChng = 1'b0;
    for (int k = 0; k < ACK_TIMEOUT + 20 && !found; k++) begin
      @(negedge clk);
      if (Err === 1'b1) begin
        found = 1'b1;
        ecyc = cyc;
        vlast = upd.Upd_valid;
      end
      nxt();
    end
    checks++;
    if (!found || ecyc - t0 != ROM_LAT + 1 + ACK_TIMEOUT) begin
      errors++;
      $display("FAIL ack_to_cycle got found=%b dt=%0d want dt=%0d",
               found, ecyc - t0, ROM_LAT + 1 + ACK_TIMEOUT);
    end
    checks++;
    if (vlast !== 1'b1) begin
      errors++;
      $display("FAIL ack_to_valid_at_err got %b want 1", vlast);
    end
    @(negedge clk);
    checks++;
    if ({upd.Upd_valid, Busy, Err} !== 3'b000) begin
      errors++;
      $display("FAIL ack_to_after got %b want 000",
               {upd.Upd_valid, Busy, Err});
    end
    nxt();
    upd.Upd_ack = 1'b1;
    nxt(5);
    checks++;
    if (hs_cnt - h0 !== 0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL ack_to_late_ack got hs=%0d err=%0d want 0 1",
               hs_cnt - h0, err_cnt - e0);
    end
  endtask

  task automatic test_wrap_reset;
    int   h0;
    int   e0 = err_cnt;
    int   t0;
    int   ecyc = 0;
    logic found = 1'b0;
    logic vlast = 1'b1;
    Sync_en = 1'b1;
    upd.Upd_ack = 1'b0;
    Address = 11'd9;
    exp_rom.push_back(11'd9);
    t0 = cyc;
    FreqChng = 1'b1;
    nxt();
    FreqChng = 1'b0;
    for (int k = 0; k < WRAP_TIMEOUT + 20 && !found; k++) begin
      @(negedge clk);
      if (Err === 1'b1) begin
        found = 1'b1;
        ecyc = cyc;
        vlast = upd.Upd_valid;
      end
      nxt();
    end
    checks++;
    if (!found || ecyc - t0 != ROM_LAT + 1 + WRAP_TIMEOUT) begin
      errors++;
      $display("FAIL wrap_to_cycle got found=%b dt=%0d want dt=%0d",
               found, ecyc - t0, ROM_LAT + 1 + WRAP_TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if ({vlast, upd.Upd_valid} !== 2'b01) begin
      errors++;
      $display("FAIL wrap_to_valid got %b want 01",
               {vlast, upd.Upd_valid});
    end
    nxt();
    Reset = 1'b1;
    Sync_en = 1'b0;
    Address = 11'd42;
    nxt();
    @(negedge clk);
    checks++;
    if ({upd.Upd_valid, Rom_en, Busy, Err} !== 4'b0000
        || upd.Pinc !== 32'h0 || upd.Wave_sel !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset got ctl=%b pinc=%h ws=%0d want 0",
               {upd.Upd_valid, Rom_en, Busy, Err},
               upd.Pinc, upd.Wave_sel);
    end
    h0 = hs_cnt;
    exp_rom.push_back(11'd42);
    exp_upd.push_back({rom_fn(11'd42), 3'd4});
    nxt();
    Reset = 1'b0;
    upd.Upd_ack = 1'b1;
    nxt(8);
    checks++;
    if (hs_cnt - h0 !== 1 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL reboot got hs=%0d err=%0d want 1 1",
               hs_cnt - h0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_sync();
    test_coalesce();
    test_mode();
    test_ack_timeout();
    test_wrap_reset();
    checks++;
    if (exp_rom.size() != 0 || exp_upd.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got rom=%0d upd=%0d want 0 0",
               exp_rom.size(), exp_upd.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
